// File: rtl/usb_rx_crc_ctrl_if.sv
// Bundle between the USB rx CRC sequencer, the bit decoder, the CRC engines
// and the packet/FIFO controller. master drives bits/flags, slave is the sequencer.
interface usb_rx_crc_ctrl_if;
  logic        sop;
  logic        bit_valid;
  logic        d_orig;
  logic        eop;
  logic        crc_ok_16;
  logic        crc_ok_5;
  logic        crc_clear;
  logic        shift_en_16;
  logic        shift_en_5;
  logic        pkt_done;
  logic [3:0]  pid;
  logic [10:0] byte_cnt;
  logic        crc_err;
  logic        len_err;
  logic        pid_err;

  modport master (
    output sop, bit_valid, d_orig, eop,
    output crc_ok_16, crc_ok_5,
    input  crc_clear, shift_en_16, shift_en_5,
    input  pkt_done, pid, byte_cnt,
    input  crc_err, len_err, pid_err
  );

  modport slave (
    input  sop, bit_valid, d_orig, eop,
    input  crc_ok_16, crc_ok_5,
    output crc_clear, shift_en_16, shift_en_5,
    output pkt_done, pid, byte_cnt,
    output crc_err, len_err, pid_err
  );
endinterface

// File: rtl/usb_rx_crc_ctrl.sv
// Receive CRC sequencer: captures/checks PID, steers CRC5/CRC16 engines,
// checks field length, pulses pkt_done with pid/byte_cnt/error status.
// Ports: clk, n_rst (async active-low), bus (usb_rx_crc_ctrl_if.slave).
module usb_rx_crc_ctrl #(
  parameter int MAX_BYTES = 1026,
  parameter int CNT_W     = 14
) (
  input logic              clk,
  input logic              n_rst,
  usb_rx_crc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, PID, DATA16, DATA5, NOCRC, CHECK, DONE
  } state_t;

  typedef enum logic [1:0] {
    K_NONE, K_D16, K_D5
  } kind_t;

  localparam logic [CNT_W-1:0] MAX_BITS =
    CNT_W'(MAX_BYTES * 8);

  state_t           state;
  kind_t            kind;
  kind_t            dec_kind;
  logic [7:0]       sr;
  logic [2:0]       pcnt;
  logic [CNT_W-1:0] bits;
  logic             perr;
  logic             short_pid;

  logic             done_q;
  logic [3:0]       pid_q;
  logic [10:0]      bc_q;
  logic             crc_err_q;
  logic             len_err_q;
  logic             pid_err_q;

  logic             step;
  logic             last_pid;
  logic             chk_bad;
  logic [7:0]       pid_next;
  logic [CNT_W-1:0] bits_inc;
  logic [CNT_W-1:0] bq;
  logic [10:0]      bc_sat;
  logic             len16;
  logic             len5;
  logic             lenn;

  // sop always wins: a bit arriving with it belongs to no packet
  assign step     = bus.bit_valid & ~bus.sop;
  assign pid_next = {bus.d_orig, sr[7:1]};
  assign last_pid = (state == PID) & step
                  & (pcnt == 3'd7);
  assign chk_bad  = pid_next[3:0] != ~pid_next[7:4];

  assign bus.crc_clear   = last_pid;
  assign bus.shift_en_16 = (state == DATA16) & step;
  assign bus.shift_en_5  = (state == DATA5) & step;

  assign bus.pkt_done = done_q;
  assign bus.pid      = pid_q;
  assign bus.byte_cnt = bc_q;
  assign bus.crc_err  = crc_err_q;
  assign bus.len_err  = len_err_q;
  assign bus.pid_err  = pid_err_q;

  assign bits_inc = (&bits) ? bits
                  : bits + CNT_W'(1);
  assign bq       = bits >> 3;
  assign bc_sat   = (bq > CNT_W'(2047)) ? 11'h7ff
                  : bq[10:0];

  assign len16 = (bits[2:0] != 3'd0)
               | (bits < CNT_W'(16))
               | (bits > MAX_BITS);
  assign len5  = bits != CNT_W'(16);
  assign lenn  = ~perr & (bits != '0);

  always_comb begin
    dec_kind = K_NONE;
    unique case (1'b1)
      chk_bad:
        dec_kind = K_NONE;
      !chk_bad && pid_next[1:0] == 2'b11:
        dec_kind = K_D16;
      !chk_bad && pid_next[1:0] == 2'b01:
        dec_kind = K_D5;
      default:
        dec_kind = K_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      kind      <= K_NONE;
      sr        <= '0;
      pcnt      <= '0;
      bits      <= '0;
      perr      <= 1'b0;
      short_pid <= 1'b0;
      done_q    <= 1'b0;
      pid_q     <= '0;
      bc_q      <= '0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      pid_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.sop) begin
        state     <= PID;
        kind      <= K_NONE;
        sr        <= '0;
        pcnt      <= '0;
        bits      <= '0;
        perr      <= 1'b0;
        short_pid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          PID: begin
            if (step) begin
              sr   <= pid_next;
              pcnt <= pcnt + 3'd1;
            end
            if (last_pid) begin
              perr <= chk_bad;
              kind <= dec_kind;
              if (bus.eop)
                state <= CHECK;
              else if (dec_kind == K_D16)
                state <= DATA16;
              else if (dec_kind == K_D5)
                state <= DATA5;
              else
                state <= NOCRC;
            end else if (bus.eop) begin
              perr      <= 1'b1;
              short_pid <= 1'b1;
              kind      <= K_NONE;
              state     <= CHECK;
            end
          end
          DATA16, DATA5, NOCRC: begin
            if (step)
              bits <= bits_inc;
            if (bus.eop)
              state <= CHECK;
          end
          // crc_ok_* has had a full cycle to reflect the last shift
          CHECK: begin
            done_q    <= 1'b1;
            pid_q     <= sr[3:0];
            bc_q      <= bc_sat;
            pid_err_q <= perr;
            unique case (kind)
              K_D16: begin
                crc_err_q <= ~bus.crc_ok_16;
                len_err_q <= len16;
              end
              K_D5: begin
                crc_err_q <= ~bus.crc_ok_5;
                len_err_q <= len5;
              end
              default: begin
                crc_err_q <= 1'b0;
                len_err_q <= short_pid | lenn;
              end
            endcase
            state <= DONE;
          end
          DONE:
            state <= IDLE;
          default:
            state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_crc_ctrl.sv
// Bench for usb_rx_crc_ctrl: behavioural CRC engines plus a packet-level
// reference model; directed and random packets.
module tb_usb_rx_crc_ctrl;

  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  usb_rx_crc_ctrl_if bus ();

  usb_rx_crc_ctrl #(
    .MAX_BYTES (1026),
    .CNT_W     (14)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int eop_cyc = 0;
  int done_cyc = 0;
  int done_n = 0;
  int n16 = 0, n5 = 0, nclr = 0;
  int b16, b5, bclr, d0;
  logic [17:0] obs = '0;
  logic [17:0] exp_st, msk;
  int exp16, exp5, expclr;
  bitq_t pkt, fld, e16, e5;

  function automatic logic [15:0] crc_of(
    input bitq_t f, input int len, input int w);
    logic [15:0] c, poly;
    bit fb;
    c    = (w == 16) ? 16'hffff : 16'h001f;
    poly = (w == 16) ? 16'ha001 : 16'h0014;
    for (int i = 0; i < len; i++) begin
      fb = c[0] ^ f[i];
      c  = c >> 1;
      if (fb) c = c ^ poly;
    end
    return c;
  endfunction

  // valid codeword: trailing w bits are the inverted CRC, LSB first
  function automatic bit cw_ok(input bitq_t f, input int w);
    logic [15:0] c;
    int n;
    n = f.size();
    if (n < w) return 1'b0;
    c = crc_of(f, n - w, w);
    for (int i = 0; i < w; i++)
      if (f[n-w+i] != !c[i]) return 1'b0;
    return 1'b1;
  endfunction

  // CRC engines as the system wires them
  always @(posedge clk) begin
    if (!n_rst) begin
      bus.crc_ok_16 <= 1'b0;
      bus.crc_ok_5  <= 1'b0;
    end else begin
      if (bus.crc_clear) begin
        e16.delete();
        e5.delete();
      end else begin
        if (bus.shift_en_16) e16.push_back(bus.d_orig);
        if (bus.shift_en_5)  e5.push_back(bus.d_orig);
      end
      bus.crc_ok_16 <= cw_ok(e16, 16);
      bus.crc_ok_5  <= cw_ok(e5, 5);
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (bus.eop) eop_cyc = cyc;
    if (bus.shift_en_16) n16++;
    if (bus.shift_en_5) n5++;
    if (bus.crc_clear) nclr++;
  end

  always @(negedge clk) begin
    if (bus.pkt_done) begin
      done_n++;
      done_cyc = cyc;
      obs = {bus.pid, bus.byte_cnt, bus.crc_err,
             bus.len_err, bus.pid_err};
    end
  end

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) fld.push_back(b[i]);
  endtask

  task automatic add_crc(input int w);
    logic [15:0] c;
    c = crc_of(fld, fld.size(), w);
    for (int i = 0; i < w; i++) fld.push_back(!c[i]);
  endtask

  task automatic build(input logic [7:0] p);
    pkt.delete();
    for (int i = 0; i < 8; i++) pkt.push_back(p[i]);
    foreach (fld[i]) pkt.push_back(fld[i]);
  endtask

  // expected status straight from the packet rules
  task automatic model();
    logic [7:0] p;
    bit bad, crc, len;
    int n, kind, bc;
    bitq_t f;
    msk = '1;
    if (pkt.size() < 8) begin
      exp_st = {4'h0, 11'd0, 1'b0, 1'b1, 1'b1};
      msk    = 18'h03fff;
      exp16 = 0; exp5 = 0; expclr = 0;
      return;
    end
    for (int i = 0; i < 8; i++) p[i] = pkt[i];
    n = pkt.size() - 8;
    for (int i = 8; i < pkt.size(); i++) f.push_back(pkt[i]);
    bad = p[3:0] != ~p[7:4];
    if (bad) kind = 0;
    else if (p[3:0] inside {4'h3, 4'hb, 4'h7, 4'hf}) kind = 16;
    else if (p[3:0] inside {4'h1, 4'h9, 4'h5, 4'hd}) kind = 5;
    else kind = 0;
    crc = (kind == 16) ? !cw_ok(f, 16)
        : (kind == 5)  ? !cw_ok(f, 5) : 1'b0;
    if (kind == 16)
      len = (n % 8 != 0) || (n < 16) || (n > 1026 * 8);
    else if (kind == 5)
      len = n != 16;
    else
      len = !bad && n != 0;
    bc = (n / 8 > 2047) ? 2047 : n / 8;
    exp_st = {p[3:0], 11'(bc), crc, len, bad};
    exp16  = (kind == 16) ? n : 0;
    exp5   = (kind == 5) ? n : 0;
    expclr = 1;
  endtask

  task automatic drive(input bit do_eop, input bit el,
                       input bit gp);
    b16 = n16; b5 = n5; bclr = nclr; d0 = done_n;
    @(negedge clk);
    bus.sop = 1'b1;
    @(negedge clk);
    bus.sop = 1'b0;
    for (int i = 0; i < pkt.size(); i++) begin
      bus.bit_valid = 1'b1;
      bus.d_orig    = pkt[i];
      bus.eop       = do_eop && el && (i == pkt.size() - 1);
      @(negedge clk);
      bus.bit_valid = 1'b0;
      bus.eop       = 1'b0;
      if (gp) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    if (do_eop && (!el || pkt.size() == 0)) begin
      bus.eop = 1'b1;
      @(negedge clk);
      bus.eop = 1'b0;
    end
    if (do_eop) repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.pkt_done, bus.pid, bus.byte_cnt, bus.crc_err,
         bus.len_err, bus.pid_err, bus.crc_clear,
         bus.shift_en_16, bus.shift_en_5} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero output(s)");
    end
    n_rst = 1'b1;
    d0 = done_n; b16 = n16; b5 = n5;
    repeat (4) begin
      @(negedge clk);
      bus.bit_valid = 1'b1;
      bus.eop = 1'b1;
      @(negedge clk);
      bus.bit_valid = 1'b0;
      bus.eop = 1'b0;
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (done_n != d0 || n16 != b16 || n5 != b5) begin
      n_fail++;
      $display("FAIL idle_ignore: done %0d shifts %0d want 0 0",
               done_n - d0, n16 - b16 + n5 - b5);
    end
  endtask

  task automatic test_token();
    fld.delete();
    add_byte(8'h00);
    add_byte(8'h10);
    build(8'h2d);
    drive(1'b1, 1'b1, 1'b0);
    n_chk++;
    if (obs !== {4'hd, 11'd2, 3'b000}) begin
      n_fail++;
      $display("FAIL token_status: got %h want %h",
               obs, {4'hd, 11'd2, 3'b000});
    end
    n_chk++;
    if (n5 - b5 != 16 || n16 != b16 || nclr - bclr != 1) begin
      n_fail++;
      $display("FAIL token_shifts: sh5 %0d sh16 %0d clr %0d want 16 0 1",
               n5 - b5, n16 - b16, nclr - bclr);
    end
    n_chk++;
    if (done_n - d0 != 1 || done_cyc != eop_cyc + 1) begin
      n_fail++;
      $display("FAIL token_latency: done %0d at %0d eop %0d",
               done_n - d0, done_cyc, eop_cyc);
    end
  endtask

  task automatic test_data();
    for (int k = 0; k < 2; k++) begin
      fld.delete();
      for (int b = 0; b < 4; b++) add_byte(8'(b));
      add_crc(16);
      if (k == 1) fld[fld.size()-1] = !fld[fld.size()-1];
      build(8'hc3);
      drive(1'b1, 1'b0, 1'b1);
      n_chk++;
      if (obs !== {4'h3, 11'd6, 1'(k), 2'b00}) begin
        n_fail++;
        $display("FAIL data_status[%0d]: got %h want %h",
                 k, obs, {4'h3, 11'd6, 1'(k), 2'b00});
      end
      n_chk++;
      if (n16 - b16 != 48 || n5 != b5) begin
        n_fail++;
        $display("FAIL data_shifts[%0d]: sh16 %0d sh5 %0d want 48 0",
                 k, n16 - b16, n5 - b5);
      end
      n_chk++;
      if (done_n - d0 != 1 || done_cyc != eop_cyc + 1) begin
        n_fail++;
        $display("FAIL data_latency[%0d]: done %0d at %0d eop %0d",
                 k, done_n - d0, done_cyc, eop_cyc);
      end
    end
  endtask

  task automatic test_handshake();
    fld.delete();
    build(8'hd2);
    drive(1'b1, 1'b0, 1'b0);
    n_chk++;
    if (obs !== {4'h2, 11'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL ack_status: got %h want %h",
               obs, {4'h2, 11'd0, 3'b000});
    end
    n_chk++;
    if (n16 != b16 || n5 != b5) begin
      n_fail++;
      $display("FAIL ack_shifts: got %0d want 0",
               n16 - b16 + n5 - b5);
    end
    build(8'hd3);
    drive(1'b1, 1'b1, 1'b0);
    n_chk++;
    if (obs !== {4'h3, 11'd0, 3'b001}) begin
      n_fail++;
      $display("FAIL bad_pid_status: got %h want %h",
               obs, {4'h3, 11'd0, 3'b001});
    end
  endtask

  task automatic test_length();
    fld.delete();
    repeat (13) fld.push_back(1'($urandom));
    build(8'h4b);
    model();
    drive(1'b1, 1'b1, 1'b1);
    n_chk++;
    if (obs[1] !== 1'b1 || obs !== exp_st) begin
      n_fail++;
      $display("FAIL data13_len: got %h want %h", obs, exp_st);
    end
    fld.delete();
    repeat (24) fld.push_back(1'($urandom));
    build(8'h2d);
    model();
    drive(1'b1, 1'b0, 1'b0);
    n_chk++;
    if (obs[1] !== 1'b1 || obs !== exp_st) begin
      n_fail++;
      $display("FAIL token24_len: got %h want %h", obs, exp_st);
    end
  endtask

  task automatic test_abort();
    int d_first;
    fld.delete();
    repeat (5) add_byte(8'($urandom));
    build(8'hc3);
    drive(1'b0, 1'b0, 1'b0);
    d_first = d0;
    fld.delete();
    build(8'hd2);
    drive(1'b1, 1'b1, 1'b0);
    n_chk++;
    if (done_n - d_first != 1 || obs !== {4'h2, 11'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL abort: dones %0d status %h want 1 %h",
               done_n - d_first, obs, {4'h2, 11'd0, 3'b000});
    end
  endtask

  task automatic test_reset_mid();
    int dd;
    fld.delete();
    repeat (10) fld.push_back(1'($urandom));
    build(8'hc3);
    drive(1'b0, 1'b0, 1'b0);
    dd = done_n;
    bus.bit_valid = 1'b1;
    n_rst = 1'b0;
    #1;
    n_chk++;
    if ({bus.pkt_done, bus.pid, bus.byte_cnt, bus.crc_err,
         bus.len_err, bus.pid_err, bus.crc_clear,
         bus.shift_en_16, bus.shift_en_5} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got nonzero output(s)");
    end
    bus.eop = 1'b1;
    @(negedge clk);
    bus.bit_valid = 1'b0;
    bus.eop = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (done_n != dd) begin
      n_fail++;
      $display("FAIL reset_mid_done: got %0d want 0", done_n - dd);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] pids [10] = '{8'hc3, 8'h4b, 8'h87, 8'h2d,
      8'h69, 8'he1, 8'hd2, 8'h5a, 8'h1e, 8'h00};
    for (int t = 0; t < 40; t++) begin
      logic [7:0] p;
      int r, k;
      bit el, gp;
      p = pids[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) p = 8'($urandom);
      fld.delete();
      r = $urandom_range(0, 3);
      if (r == 0) begin
        repeat ($urandom_range(0, 20)) fld.push_back(1'($urandom));
      end else if (r == 2) begin
        repeat (11) fld.push_back(1'($urandom));
        add_crc(5);
      end else begin
        repeat ($urandom_range(0, 12)) add_byte(8'($urandom));
        add_crc(16);
        if (r == 3) begin
          k = $urandom_range(0, fld.size() - 1);
          fld[k] = !fld[k];
        end
      end
      build(p);
      if ($urandom_range(0, 15) == 0) begin
        k = $urandom_range(1, 7);
        while (pkt.size() > k) void'(pkt.pop_back());
      end
      el = 1'($urandom);
      gp = 1'($urandom);
      model();
      drive(1'b1, el, gp);
      n_chk++;
      if ((obs & msk) !== (exp_st & msk)) begin
        n_fail++;
        $display("FAIL rnd%0d_status: got %h want %h",
                 t, obs & msk, exp_st & msk);
      end
      n_chk++;
      if (n16 - b16 != exp16 || n5 - b5 != exp5 ||
          nclr - bclr != expclr) begin
        n_fail++;
        $display("FAIL rnd%0d_shifts: %0d/%0d/%0d want %0d/%0d/%0d",
                 t, n16 - b16, n5 - b5, nclr - bclr,
                 exp16, exp5, expclr);
      end
      n_chk++;
      if (done_n - d0 != 1 || done_cyc != eop_cyc + 1) begin
        n_fail++;
        $display("FAIL rnd%0d_latency: done %0d at %0d eop %0d",
                 t, done_n - d0, done_cyc, eop_cyc);
      end
    end
  endtask

  initial begin
    bus.sop = 1'b0;
    bus.bit_valid = 1'b0;
    bus.d_orig = 1'b0;
    bus.eop = 1'b0;
    test_reset();
    test_token();
    test_data();
    test_handshake();
    test_length();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_rx_crc_ctrl.md
Name: usb_rx_crc_ctrl

Overview:
Receive-side CRC sequencer for the USB packet decoder. It takes the destuffed, NRZI-decoded bit stream and validates each packet:
- Captures and checks the PID.
- Drives the clear/shift controls of the shared CRC16 engine and the CRC5 engine.
- Checks field length.
- At EOP, reports one status pulse carrying PID, byte count and error flags to the packet/FIFO controller.

Parameters:
MAX_BYTES, 1026, maximum data-field bytes after the PID, including 2 CRC bytes. Longer packets set len_err.
CNT_W, 14, width of the bit counter. Must hold MAX_BYTES*8.

Ports:
clk  input  1  system clock
n_rst  input  1  reset n_rst, asynchronous, active-low; clock clk
sop  input  1  one-cycle pulse: SYNC detected, next valid bit is PID bit 0
bit_valid  input  1  one-cycle strobe: d_orig carries a new destuffed bit
d_orig  input  1  decoded data bit, LSB first; passed straight to both CRC engines
eop  input  1  one-cycle pulse: end of packet; may coincide with bit_valid
crc_ok_16  input  1  residual-match flag from CRC16 engine
crc_ok_5  input  1  residual-match flag from CRC5 engine
crc_clear  output  1  clear to both engines
shift_en_16  output  1  shift enable to CRC16 engine
shift_en_5  output  1  shift enable to CRC5 engine
pkt_done  output  1  one-cycle pulse: status outputs valid
pid  output  4  captured PID[3:0], held until next pkt_done
byte_cnt  output  11  data-field bytes after PID, CRC bytes included
crc_err  output  1  CRC residual mismatch
len_err  output  1  illegal field length
pid_err  output  1  PID check nibble mismatch

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0.
- States: IDLE, PID, DATA16, DATA5, NOCRC, CHECK, DONE.
- IDLE:
  - sop -> PID, with bit counter cleared.
  - bit_valid and eop are ignored.
- PID:
  - Each bit_valid shifts d_orig into an 8-bit shift register, LSB first.
  - On the 8th bit, evaluate the PID:
    - PID[3:0] != ~PID[7:4] -> pid_err latched, go NOCRC.
    - Data PIDs 0x3, 0xB, 0x7, 0xF -> DATA16.
    - Token PIDs 0x1, 0x9, 0x5, 0xD -> DATA5.
    - All others (handshake/special) -> NOCRC.
  - crc_clear is asserted combinationally in the same cycle as the 8th bit, so the engines are cleared before the first data bit.
- DATA16 / DATA5:
  - shift_en_16 / shift_en_5 equals bit_valid; the other enable stays 0.
  - Bit counter increments per bit_valid, saturating at all-ones.
- NOCRC: bits are counted; no shifts.
- eop in PID/DATA/NOCRC state:
  - A coincident bit_valid is processed first (shifted and counted).
  - Then go to CHECK.
- eop in PID state before 8 bits -> pid_err=1, len_err=1.
- CHECK (one cycle; lets the engine register settle):
  - DATA16: crc_err = ~crc_ok_16. len_err = (bits mod 8 != 0) | (bits < 16) | (bits > MAX_BYTES*8).
  - DATA5: crc_err = ~crc_ok_5. len_err = (bits != 16).
  - NOCRC: crc_err = 0. len_err = (bits != 0), unless pid_err is set.
  - byte_cnt = bits >> 3, saturated at 11 bits.
  - Then go to DONE.
- DONE: pkt_done = 1 for one cycle; status outputs register-held until the next pkt_done. Return to IDLE.
- sop in any non-IDLE state:
  - Abort the current packet; no pkt_done for it.
  - Restart in PID with counters cleared and pid_err cleared.
  - crc_clear is not asserted until that packet's PID completes.
- Latency: pkt_done occurs exactly 2 cycles after the eop cycle.
- n_rst asserted mid-packet: immediate return to reset values; no pkt_done.

Test Plan:
- Token: sop, then bits of bytes 0x2D 0x00 0x10 (SETUP, addr 0, endp 0, CRC5 0x02), eop on last bit -> shift_en_5 pulses 16 times, shift_en_16 never, crc_clear once; pkt_done 2 cycles after eop with pid=0xD, byte_cnt=2, all errors 0.
- Data: DATA0 (0xC3), payload 0x00 0x01 0x02 0x03, correct CRC16 bytes from the bench model -> 48 shift_en_16 pulses; pkt_done with pid=0x3, byte_cnt=6, errors 0. Same packet with the last CRC bit flipped -> crc_err=1 only.
- Handshake: ACK 0xD2 then eop -> no shift enables; pid=0x2, byte_cnt=0, errors 0. Byte 0xD3 -> pid_err=1.
- Length: DATA1 (0x4B) plus 13 bits then eop -> len_err=1. Token plus 24 bits -> len_err=1.
- Abort/reset: second sop after 5 data bytes -> no pkt_done for the first packet; the second packet (ACK) reports cleanly. n_rst low mid-DATA16 -> all outputs 0 immediately, no pkt_done.
- eop coincident with final bit_valid -> final bit shifted, and pkt_done timing still eop+2.
